// File: rtl/fft_bfly_switch.sv
// fft_bfly_switch: routes bank A/B memory read beats to butterfly operand pairs.
// Direct mode forwards {a, b} per beat; pair mode regroups two beats into
// {a0, a1} and {b0, b1}, with the second entry held one cycle in a pending slot.
// Output side is a small FIFO whose head drives the butterfly operands.
module fft_bfly_switch #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_mode,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic                  i_sop,
    input  logic                  i_eop,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_ain,
    output logic [DATA_WIDTH-1:0] o_bin,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_eop,
    output logic                  o_pair_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * DATA_WIDTH + ADDR_WIDTH + 1;
    // accept only while at least two entries stay free after any pending push
    localparam logic [PW+1:0] OCC_LIMIT = (PW + 2)'(FIFO_DEPTH - 2);

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic [PW:0]           count;
    logic [PW+1:0]         occ;

    logic                  mode_q;
    logic                  parity;
    logic [DATA_WIDTH-1:0] a0_q;
    logic [DATA_WIDTH-1:0] b0_q;
    logic [ADDR_WIDTH-1:0] addr0_q;
    logic                  pend_valid;
    logic [EW-1:0]         pend_q;
    logic                  pair_err_q;

    logic                  accept;
    logic                  pop;
    logic                  eff_mode;
    logic                  eff_par;
    logic                  acc_push;
    logic [EW-1:0]         acc_entry;
    logic                  push;
    logic [EW-1:0]         push_entry;
    logic [EW-1:0]         head;

    assign count = wr_ptr - rd_ptr;
    assign occ   = {1'b0, count} + {{(PW + 1){1'b0}}, pend_valid};

    // The pending slot drains the cycle after a pair beat1. A direct-mode sop
    // in that cycle would need a second push, so it is held off one cycle.
    assign i_ready = (occ <= OCC_LIMIT) && !(pend_valid && i_sop && i_mode);

    assign accept   = i_valid && i_ready;
    assign o_valid  = (wr_ptr != rd_ptr);
    assign pop      = o_valid && o_ready;
    assign eff_mode = i_sop ? i_mode : mode_q;
    assign eff_par  = i_sop ? 1'b0 : parity;

    // Select what the accepted beat pushes (direct entry or the {a0, a1} pair)
    always_comb begin
        acc_push  = 1'b0;
        acc_entry = {i_a_data, i_b_data, i_addr, i_eop};
        if (accept) begin
            if (eff_mode) begin
                acc_push = 1'b1;
            end else if (eff_par) begin
                acc_push  = 1'b1;
                acc_entry = {a0_q, i_a_data, addr0_q, 1'b0};
            end
        end
    end

    // Pending entry and beat pushes never coincide, pending wins for safety
    assign push       = pend_valid || acc_push;
    assign push_entry = pend_valid ? pend_q : acc_entry;

    // FIFO storage; head is read combinationally for single-cycle latency
    always_ff @(posedge clk) begin
        if (push && !i_flush) begin
            mem[wr_ptr[PW-1:0]] <= push_entry;
        end
    end

    assign head = mem[rd_ptr[PW-1:0]];
    assign {o_ain, o_bin, o_addr, o_eop} = o_valid ? head : '0;
    assign o_pair_err = pair_err_q;

    // Pointers, pair tracking, pending slot and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mode_q     <= 1'b0;
            parity     <= 1'b0;
            a0_q       <= '0;
            b0_q       <= '0;
            addr0_q    <= '0;
            pend_valid <= 1'b0;
            pend_q     <= '0;
            pair_err_q <= 1'b0;
        end else if (i_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            parity     <= 1'b0;
            pend_valid <= 1'b0;
            pair_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            pend_valid <= 1'b0;
            pair_err_q <= 1'b0;
            if (accept) begin
                mode_q <= eff_mode;
                // a new sop while a pair beat0 is held orphans that beat0
                if (i_sop && parity) pair_err_q <= 1'b1;
                if (eff_mode) begin
                    parity <= 1'b0;
                end else if (!eff_par) begin
                    if (i_eop) begin
                        pair_err_q <= 1'b1;
                        parity     <= 1'b0;
                    end else begin
                        a0_q    <= i_a_data;
                        b0_q    <= i_b_data;
                        addr0_q <= i_addr;
                        parity  <= 1'b1;
                    end
                end else begin
                    pend_q     <= {b0_q, i_b_data, i_addr, i_eop};
                    pend_valid <= 1'b1;
                    parity     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_bfly_switch.sv
// Directed bench for fft_bfly_switch: direct, pair, backpressure, orphan,
// odd eop, flush and reset scenarios with hand-computed expectations.
module tb_fft_bfly_switch;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_mode = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic          i_sop = 1'b0;
    logic          i_eop = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_a_data = '0;
    logic [DW-1:0] i_b_data = '0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [DW-1:0] o_ain;
    logic [DW-1:0] o_bin;
    logic [AW-1:0] o_addr;
    logic          o_eop;
    logic          o_pair_err;

    int checks = 0;
    int errors = 0;

    fft_bfly_switch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_mode(i_mode),
        .i_valid(i_valid), .i_ready(i_ready), .i_sop(i_sop), .i_eop(i_eop),
        .i_addr(i_addr), .i_a_data(i_a_data), .i_b_data(i_b_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_ain(o_ain), .o_bin(o_bin),
        .o_addr(o_addr), .o_eop(o_eop), .o_pair_err(o_pair_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] word(input logic v, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [AW-1:0] ad,
                                          input logic e);
        return 128'({v, a, b, ad, e});
    endfunction

    function automatic logic [127:0] cur();
        return 128'({o_valid, o_ain, o_bin, o_addr, o_eop});
    endfunction

    task automatic beat(input logic sop, input logic eop, input logic mode,
                        input int ad, input int a, input int b);
        i_valid  = 1'b1;
        i_sop    = sop;
        i_eop    = eop;
        i_mode   = mode;
        i_addr   = AW'(ad);
        i_a_data = DW'(a);
        i_b_data = DW'(b);
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
    endtask

    task automatic queue_three();
        o_ready = 1'b0;
        @(negedge clk); beat(1, 0, 1, 20, 'h21, 'h22);
        @(negedge clk); beat(0, 0, 1, 21, 'h31, 'h32);
        @(negedge clk); beat(0, 0, 1, 22, 'h41, 'h42);
        @(negedge clk); idle();
        @(negedge clk);
        chk("q3_head", cur(), word(1, 'h21, 'h22, 20, 0));
        chk("q3_ready_low", 128'(i_ready), 128'(0));
    endtask

    initial begin
        int bi;
        int n;
        int first_low;
        int bi_hold;
        int p;
        logic [127:0] exp_w;

        // reset state
        #1;
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_err", 128'(o_pair_err), 128'(0));
        chk("rst_out", cur(), 128'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 128'(i_ready), 128'(1));

        // direct mode
        o_ready = 1'b1;
        @(negedge clk); beat(1, 0, 1, 0, 1, 2);
        @(negedge clk);
        chk("dir_out0", cur(), word(1, 1, 2, 0, 0));
        beat(0, 1, 1, 1, 3, 4);
        @(negedge clk);
        chk("dir_out1", cur(), word(1, 3, 4, 1, 1));
        idle();
        @(negedge clk);
        chk("dir_empty", 128'(o_valid), 128'(0));

        // pair mode
        @(negedge clk); beat(1, 0, 0, 4, 10, 20);
        @(negedge clk);
        chk("pair_beat0_nopush", 128'(o_valid), 128'(0));
        beat(0, 1, 0, 5, 11, 21);
        @(negedge clk);
        chk("pair_out0", cur(), word(1, 10, 11, 4, 0));
        idle();
        @(negedge clk);
        chk("pair_out1", cur(), word(1, 20, 21, 5, 1));
        @(negedge clk);
        chk("pair_empty", 128'(o_valid), 128'(0));

        // orphan beat0 followed by a new sop
        @(negedge clk); beat(1, 0, 0, 8, 'h88, 'h99);
        @(negedge clk);
        chk("orph_err0", 128'(o_pair_err), 128'(0));
        beat(1, 0, 0, 0, 'h30, 'h40);
        @(negedge clk);
        chk("orph_err1", 128'(o_pair_err), 128'(1));
        chk("orph_noout", 128'(o_valid), 128'(0));
        beat(0, 1, 0, 1, 'h31, 'h41);
        @(negedge clk);
        chk("orph_err_clr", 128'(o_pair_err), 128'(0));
        chk("orph_out0", cur(), word(1, 'h30, 'h31, 0, 0));
        idle();
        @(negedge clk);
        chk("orph_out1", cur(), word(1, 'h40, 'h41, 1, 1));
        @(negedge clk);
        chk("orph_empty", 128'(o_valid), 128'(0));

        // eop on a pair beat0
        @(negedge clk); beat(1, 1, 0, 2, 'h55, 'h66);
        @(negedge clk);
        idle();
        chk("odd_err", 128'(o_pair_err), 128'(1));
        chk("odd_noout", 128'(o_valid), 128'(0));
        @(negedge clk);
        chk("odd_err_clr", 128'(o_pair_err), 128'(0));
        chk("odd_noout2", 128'(o_valid), 128'(0));
        beat(0, 0, 0, 6, 'h70, 'h80);
        @(negedge clk); beat(0, 1, 0, 7, 'h71, 'h81);
        @(negedge clk);
        chk("odd_next0", cur(), word(1, 'h70, 'h71, 6, 0));
        idle();
        @(negedge clk);
        chk("odd_next1", cur(), word(1, 'h80, 'h81, 7, 1));
        @(negedge clk);
        chk("odd_empty", 128'(o_valid), 128'(0));

        // backpressure: 16 pair beats, o_ready held low then released
        bi = 0; n = 0; first_low = -1; bi_hold = -1;
        for (int cyc = 0; cyc < 300 && n < 16; cyc++) begin
            @(negedge clk);
            o_ready = (cyc >= 12);
            if (bi < 16) beat(bi == 0, bi == 15, 0, bi, 'h100 + bi, 'h200 + bi);
            else idle();
            #1;
            if (!i_ready && first_low < 0) first_low = bi;
            if (cyc == 11) bi_hold = bi;
            if (o_valid && o_ready) begin
                p = n / 2;
                if (n % 2 == 0)
                    exp_w = word(1, DW'('h100 + 2 * p), DW'('h101 + 2 * p), AW'(2 * p), 0);
                else
                    exp_w = word(1, DW'('h200 + 2 * p), DW'('h201 + 2 * p), AW'(2 * p + 1),
                                 (2 * p + 1) == 15);
                chk("bp_out", cur(), exp_w);
                n++;
            end
            if (i_valid && i_ready) bi++;
        end
        chk("bp_count", 128'(n), 128'(16));
        chk("bp_ready_fall", 128'(first_low), 128'(4));
        chk("bp_hold", 128'(bi_hold), 128'(4));
        @(negedge clk);
        idle();
        chk("bp_empty", 128'(o_valid), 128'(0));

        // flush with three entries queued
        queue_three();
        i_flush = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("fl_valid", 128'(o_valid), 128'(0));
        chk("fl_ready", 128'(i_ready), 128'(1));
        beat(1, 1, 1, 9, 'hA, 'hB);
        @(negedge clk);
        chk("fl_new", cur(), word(1, 'hA, 'hB, 9, 1));
        idle();
        @(negedge clk);
        chk("fl_empty", 128'(o_valid), 128'(0));

        // reset with three entries queued
        queue_three();
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 128'(o_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_ready", 128'(i_ready), 128'(1));
        chk("rs_err", 128'(o_pair_err), 128'(0));
        o_ready = 1'b1;
        beat(1, 0, 0, 12, 'hC0, 'hD0);
        @(negedge clk); beat(0, 1, 0, 13, 'hC1, 'hD1);
        @(negedge clk);
        chk("rs_new0", cur(), word(1, 'hC0, 'hC1, 12, 0));
        idle();
        @(negedge clk);
        chk("rs_new1", cur(), word(1, 'hD0, 'hD1, 13, 1));
        @(negedge clk);
        chk("rs_empty", 128'(o_valid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
